// File: rtl/riscv_id_ex_stage.sv
// riscv_id_ex_stage: ID/EX pipeline register with operand forwarding and ALU control decode
module riscv_id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic        exmem_wen,
   input  logic        memwb_wen,
   input  logic [4:0]  exmem_rd,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] exmem_result,
   input  logic [31:0] memwb_result,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] SrcA,
   output logic [31:0] SrcB,
   output logic        Ainv,
   output logic        Binv,
   output logic [2:0]  ALUsel,
   output logic [4:0]  rd,
   output logic        reg_write,
   output logic        illegal
);
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                          OP_S = 7'b0100011, OP_B = 7'b1100011;
   localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010, C_SUB = 5'b01010,
                          C_XOR = 5'b00100, C_SRA = 5'b00101, C_SLL = 5'b00110, C_SRL = 5'b00111,
                          C_SLT = 5'b01011;
   logic [6:0]  w_op;
   logic [4:0]  w_rd, w_rs1, w_rs2, w_ctl;
   logic [2:0]  w_f3;
   logic        w_f7b5, w_load, w_known, w_rw;
   logic [31:0] w_fa, w_fb;
   logic        r_valid, r_rw, r_ill;
   logic [31:0] r_a, r_b;
   logic [4:0]  r_ctl, r_rd;
   assign w_op    = instr[6:0];
   assign w_rd    = instr[11:7];
   assign w_f3    = instr[14:12];
   assign w_rs1   = instr[19:15];
   assign w_rs2   = instr[24:20];
   assign w_f7b5  = instr[30];
   assign in_ready = !r_valid || out_ready;
   assign w_load  = in_valid && in_ready && !flush;
   assign w_fa = (exmem_wen && exmem_rd == w_rs1 && w_rs1 != 5'd0) ? exmem_result :
                 (memwb_wen && memwb_rd == w_rs1 && w_rs1 != 5'd0) ? memwb_result : rs1_data;
   assign w_fb = (exmem_wen && exmem_rd == w_rs2 && w_rs2 != 5'd0) ? exmem_result :
                 (memwb_wen && memwb_rd == w_rs2 && w_rs2 != 5'd0) ? memwb_result : rs2_data;
   assign w_known = w_op == OP_R || w_op == OP_I || w_op == OP_L || w_op == OP_S || w_op == OP_B;
   assign w_rw    = (w_op == OP_R || w_op == OP_I || w_op == OP_L) && w_rd != 5'd0;
   // ALU control: arithmetic/immediate ops decode funct3, branches compare by subtraction, all else adds
   always_comb begin
      w_ctl = C_ADD;
      if (w_op == OP_R || w_op == OP_I)
         case (w_f3)
            3'b000:  w_ctl = (w_op == OP_R && w_f7b5) ? C_SUB : C_ADD;
            3'b001:  w_ctl = C_SLL;
            3'b010:  w_ctl = C_SLT;
            3'b011:  w_ctl = C_SLT;
            3'b100:  w_ctl = C_XOR;
            3'b101:  w_ctl = w_f7b5 ? C_SRA : C_SRL;
            3'b110:  w_ctl = C_OR;
            default: w_ctl = C_AND;
         endcase
      else if (w_op == OP_B)
         w_ctl = C_SUB;
   end
   // Pipeline register: reset beats flush beats load; data holds whenever nothing loads
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_ctl   <= '0;
         r_rd    <= '0;
         r_rw    <= 1'b0;
         r_ill   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_a     <= w_fa;
         r_b     <= (w_op == OP_I || w_op == OP_L || w_op == OP_S) ? imm : w_fb;
         r_ctl   <= w_ctl;
         r_rd    <= w_rd;
         r_rw    <= w_rw;
         r_ill   <= !w_known;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
   assign out_valid = r_valid;
   assign SrcA      = r_a;
   assign SrcB      = r_b;
   assign {Ainv, Binv, ALUsel} = r_ctl;
   assign rd        = r_rd;
   assign reg_write = r_rw;
   assign illegal   = r_ill;
endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// tb_riscv_id_ex_stage: scoreboard bench for the ID/EX stage
module tb_riscv_id_ex_stage;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  ctl;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
   logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0, imm = '0, exmem_result = '0, memwb_result = '0;
   logic        exmem_wen = 1'b0, memwb_wen = 1'b0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0, rd;
   logic [31:0] SrcA, SrcB;
   logic        Ainv, Binv, reg_write, illegal;
   logic [2:0]  ALUsel;
   int          n_cmp = 0, n_err = 0;
   bit          sb_on = 1'b0;
   exp_t        q[$];
   riscv_id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_result(exmem_result), .memwb_result(memwb_result), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
      .Ainv(Ainv), .Binv(Binv), .ALUsel(ALUsel), .rd(rd), .reg_write(reg_write), .illegal(illegal)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
      return {f7, r2, r1, f3, d, op};
   endfunction
   function automatic exp_t model();
      exp_t e;
      logic [6:0] op;
      logic [4:0] s1, s2;
      logic [31:0] fb;
      op = instr[6:0];
      s1 = instr[19:15];
      s2 = instr[24:20];
      e.a = rs1_data;
      if (s1 != 0 && memwb_wen && memwb_rd == s1) e.a = memwb_result;
      if (s1 != 0 && exmem_wen && exmem_rd == s1) e.a = exmem_result;
      fb = rs2_data;
      if (s2 != 0 && memwb_wen && memwb_rd == s2) fb = memwb_result;
      if (s2 != 0 && exmem_wen && exmem_rd == s2) fb = exmem_result;
      e.b = (op == 7'h13 || op == 7'h03 || op == 7'h23) ? imm : fb;
      e.rd = instr[11:7];
      e.rw = (op == 7'h33 || op == 7'h13 || op == 7'h03) && e.rd != 0;
      e.ill = !(op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63);
      e.ctl = 5'b00010;
      if (op == 7'h63) e.ctl = 5'b01010;
      if (op == 7'h33 || op == 7'h13)
         case (instr[14:12])
            3'd0: e.ctl = (op == 7'h33 && instr[30]) ? 5'b01010 : 5'b00010;
            3'd1: e.ctl = 5'b00110;
            3'd2, 3'd3: e.ctl = 5'b01011;
            3'd4: e.ctl = 5'b00100;
            3'd5: e.ctl = instr[30] ? 5'b00101 : 5'b00111;
            3'd6: e.ctl = 5'b00001;
            default: e.ctl = 5'b00000;
         endcase
      return e;
   endfunction
   // Scoreboard: checks the held entry every cycle, retires it on consume/flush/reset, queues accepts
   always @(negedge clk) begin
      exp_t e;
      bit acc;
      if (sb_on) begin
         acc = in_valid && !flush && !rst && (q.size() == 0 || out_ready);
         n_cmp++;
         if (out_valid !== (q.size() != 0)) begin
            n_err++;
            $display("FAIL sb_valid: out_valid=%b expected=%b", out_valid, q.size() != 0);
         end
         n_cmp++;
         if (in_ready !== (q.size() == 0 || out_ready)) begin
            n_err++;
            $display("FAIL sb_in_ready: got=%b expected=%b", in_ready, q.size() == 0 || out_ready);
         end
         if (q.size() != 0) begin
            e = q[0];
            n_cmp++;
            if ({SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal} !== e) begin
               n_err++;
               $display("FAIL sb_data: got A=%h B=%h ctl=%b rd=%0d rw=%b ill=%b exp A=%h B=%h ctl=%b rd=%0d rw=%b ill=%b",
                        SrcA, SrcB, {Ainv, Binv, ALUsel}, rd, reg_write, illegal, e.a, e.b, e.ctl, e.rd, e.rw, e.ill);
            end
            if (rst || flush || out_ready) void'(q.pop_front());
         end
         if (rst) q.delete();
         if (acc) q.push_back(model());
      end
   end
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      in_valid = 1'b1;
      instr = 32'h002081B3;
      rs1_data = 32'h11;
      step();
      sb_on = 1'b1;
      step();
      n_cmp++;
      if ({out_valid, SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b A=%h B=%h ctl=%b rd=%0d rw=%b ill=%b expected all zero",
                  out_valid, SrcA, SrcB, {Ainv, Binv, ALUsel}, rd, reg_write, illegal);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got=%b expected=1", in_ready);
      end
   endtask
   task automatic test_add();
      instr = 32'h002081B3;
      rs1_data = 5;
      rs2_data = 7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write} !== {1'b1, 32'd5, 32'd7, 5'b00010, 5'd3, 1'b1}) begin
         n_err++;
         $display("FAIL add: got v=%b A=%0d B=%0d ctl=%b rd=%0d rw=%b expected 1 5 7 00010 3 1",
                  out_valid, SrcA, SrcB, {Ainv, Binv, ALUsel}, rd, reg_write);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL add_drain: out_valid=%b expected=0", out_valid);
      end
   endtask
   task automatic test_sub_fwd();
      instr = 32'h402081B3;
      rs1_data = 32'h99;
      exmem_wen = 1'b1; exmem_rd = 1; exmem_result = 32'h10;
      memwb_wen = 1'b1; memwb_rd = 1; memwb_result = 32'h20;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if ({SrcA, Ainv, Binv, ALUsel} !== {32'h10, 5'b01010}) begin
         n_err++;
         $display("FAIL sub_fwd: got A=%h ctl=%b expected 10 01010", SrcA, {Ainv, Binv, ALUsel});
      end
      exmem_wen = 1'b0;
      instr = mk(7'h00, 5'd4, 5'd1, 3'd0, 5'd6, 7'h33);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (SrcA !== 32'h20) begin
         n_err++;
         $display("FAIL memwb_fwd: got A=%h expected 20", SrcA);
      end
      memwb_wen = 1'b0;
      step();
   endtask
   task automatic test_srai_x0();
      instr = 32'h40335293;
      imm = 3;
      rs1_data = 32'h80;
      in_valid = 1'b1;
      step();
      n_cmp++;
      if ({SrcB, Ainv, Binv, ALUsel, rd} !== {32'd3, 5'b00101, 5'd5}) begin
         n_err++;
         $display("FAIL srai: got B=%0d ctl=%b rd=%0d expected 3 00101 5", SrcB, {Ainv, Binv, ALUsel}, rd);
      end
      instr = 32'h00900393;
      imm = 9;
      rs1_data = 32'h55;
      exmem_wen = 1'b1; exmem_rd = 0; exmem_result = 32'hDEAD;
      memwb_wen = 1'b1; memwb_rd = 0; memwb_result = 32'hBEEF;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (SrcA !== 32'h55) begin
         n_err++;
         $display("FAIL x0_no_fwd: got A=%h expected 55", SrcA);
      end
      exmem_wen = 1'b0;
      memwb_wen = 1'b0;
      step();
   endtask
   task automatic test_stall();
      logic [75:0] held;
      instr = mk(7'h00, 5'd2, 5'd1, 3'd6, 5'd9, 7'h33);
      rs1_data = 32'hA;
      rs2_data = 32'hB;
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      held = {SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal};
      instr = mk(7'h00, 5'd2, 5'd1, 3'd4, 5'd12, 7'h33);
      rs1_data = 32'hC;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || {SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal} !== held) begin
            n_err++;
            $display("FAIL stall_hold: cycle %0d in_ready=%b out_valid=%b outputs=%h expected 0 1 %h", i, in_ready, out_valid,
                     {SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal}, held);
         end
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, rd, SrcA} !== {1'b1, 5'd12, 32'hC}) begin
         n_err++;
         $display("FAIL stall_release: got v=%b rd=%0d A=%h expected 1 12 c", out_valid, rd, SrcA);
      end
      step();
   endtask
   task automatic test_flush();
      instr = 32'h002081B3;
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_incoming: out_valid=%b expected=0", out_valid);
      end
      flush = 1'b0;
      out_ready = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_held: out_valid=%b expected=0", out_valid);
      end
      out_ready = 1'b1;
   endtask
   task automatic test_rst_mid_stall();
      instr = mk(7'h20, 5'd2, 5'd1, 3'd5, 5'd7, 7'h33);
      rs1_data = 32'h1234;
      rs2_data = 32'h5678;
      in_valid = 1'b1;
      out_ready = 1'b0;
      step(2);
      rst = 1'b1;
      step();
      n_cmp++;
      if ({out_valid, SrcA, SrcB, Ainv, Binv, ALUsel, rd, reg_write, illegal} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_stall: got v=%b A=%h B=%h ctl=%b rd=%0d rw=%b ill=%b expected all zero",
                  out_valid, SrcA, SrcB, {Ainv, Binv, ALUsel}, rd, reg_write, illegal);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
   endtask
   task automatic test_illegal();
      instr = mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h7F);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if ({illegal, reg_write, out_valid, Ainv, Binv, ALUsel} !== {3'b101, 5'b00010}) begin
         n_err++;
         $display("FAIL illegal: got ill=%b rw=%b v=%b ctl=%b expected 1 0 1 00010", illegal, reg_write, out_valid,
                  {Ainv, Binv, ALUsel});
      end
      step();
   endtask
   task automatic test_decode_table();
      logic [6:0] ops[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
      for (int o = 0; o < 5; o++)
         for (int f = 0; f < 16; f++) begin
            instr = mk({1'b0, f[3], 5'd0}, 5'd2, 5'd1, f[2:0], (f == 3) ? 5'd0 : 5'd8, ops[o]);
            imm = $urandom;
            rs1_data = $urandom;
            rs2_data = $urandom;
            in_valid = 1'b1;
            step();
         end
      in_valid = 1'b0;
      step();
   endtask
   task automatic test_back_to_back();
      logic [6:0] ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h37};
      for (int i = 0; i < 300; i++) begin
         instr = mk($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                    ops[$urandom_range(0, 6)]);
         rs1_data = $urandom;
         rs2_data = $urandom;
         imm = $urandom;
         exmem_wen = $urandom; exmem_rd = $urandom_range(0, 3); exmem_result = $urandom;
         memwb_wen = $urandom; memwb_rd = $urandom_range(0, 3); memwb_result = $urandom;
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 15) == 0;
         step();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      exmem_wen = 1'b0;
      memwb_wen = 1'b0;
      step(2);
   endtask
   initial begin
      test_reset();
      test_add();
      test_sub_fwd();
      test_srai_x0();
      test_stall();
      test_flush();
      test_rst_mid_stall();
      test_illegal();
      test_decode_table();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/riscv_id_ex_stage.md
RISCV_ID_EX_STAGE -- requirements
Module: riscv_id_ex_stage

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst, applied on the rising edge of clk.
REQ-002 The ports SHALL be, one per line, as name, direction, width, meaning:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 in_valid  in  1  decode stage holds a valid instruction
 in_ready  out  1  stage accepts on this edge
 instr  in  32  instruction word
 rs1_data, rs2_data  in  32 each  register-file read data
 imm  in  32  sign-extended immediate from decode
 exmem_wen, memwb_wen  in  1 each  forward-source write enables
 exmem_rd, memwb_rd  in  5 each  forward-source destination registers
 exmem_result, memwb_result  in  32 each  forward-source data
 flush  in  1  kill the held and incoming instruction
 out_valid  out  1  registered outputs hold a valid instruction
 out_ready  in  1  execute stage consumes on this edge
 SrcA, SrcB  out  32 each  ALU operands
 Ainv, Binv  out  1 each  ALU invert controls
 ALUsel  out  3  ALU operation select
 rd  out  5  destination register
 reg_write  out  1  writeback enable
 illegal  out  1  unsupported opcode

Function
REQ-003 in_ready SHALL equal (!out_valid || out_ready); it is combinational and does not depend on in_valid.
REQ-004 The stage SHALL load on a rising edge when in_valid && in_ready && !flush; out_valid becomes 1 on that edge.
REQ-005 When out_valid && out_ready and no new load occurs, out_valid SHALL clear on the next edge.
REQ-006 When out_valid && !out_ready (stall), all outputs SHALL hold their values unchanged.
REQ-007 When flush is asserted, out_valid SHALL become 0 on the next edge; flush has priority over load; the data registers may keep stale values.
REQ-008 Fields SHALL decode as: opcode = instr[6:0], rd = instr[11:7], funct3 = instr[14:12], rs1 = instr[19:15], rs2 = instr[24:20], f7b5 = instr[30].
REQ-009 Forwarded A SHALL be selected in this priority order: exmem_result if exmem_wen && exmem_rd == rs1 && rs1 != 0; else memwb_result under the same rule using memwb; else rs1_data. Forwarded B SHALL use the same rule on rs2.
REQ-010 Register x0 SHALL never be forwarded; rs1 == 0 always selects rs1_data.
REQ-011 SrcA SHALL be forwarded A; SrcB SHALL be imm for opcodes 0010011, 0000011 and 0100011, and forwarded B otherwise.
REQ-012 {Ainv, Binv, ALUsel} SHALL be encoded as: AND = 00000, OR = 00001, ADD = 00010, SUB = 01010, XOR = 00100, SRA = 00101, SLL = 00110, SRL = 00111, SLT = 01011.
REQ-013 For opcodes 0110011 and 0010011, funct3 SHALL map as: 000 -> ADD, or SUB only when opcode is 0110011 and f7b5 = 1; 001 -> SLL; 010 and 011 -> SLT; 100 -> XOR; 101 -> SRA if f7b5 = 1, else SRL; 110 -> OR; 111 -> AND.
REQ-014 Opcodes 0000011 and 0100011 SHALL map to ADD; opcode 1100011 SHALL map to SUB.
REQ-015 reg_write SHALL be 1 for opcodes 0110011, 0010011 and 0000011, and 0 otherwise; reg_write SHALL also be forced to 0 when rd == 0.
REQ-016 Any other opcode SHALL register illegal = 1, ADD encoding, reg_write = 0 and out_valid = 1.
REQ-017 All outputs except in_ready SHALL be registered, giving one cycle of latency from acceptance to out_valid.

Reset
REQ-018 While rst = 1, on each edge: out_valid = 0, SrcA = 0, SrcB = 0, Ainv = 0, Binv = 0, ALUsel = 0, rd = 0, reg_write = 0, illegal = 0.
REQ-019 rst SHALL override both flush and load; an instruction presented during reset SHALL be discarded.
REQ-020 in_ready SHALL read 1 in the cycle after reset is released.

Verification
REQ-021 Accept add x3,x1,x2 (0x002081B3) with rs1_data = 5, rs2_data = 7 and no forwarding -> next edge: out_valid = 1, SrcA = 5, SrcB = 7, {Ainv,Binv,ALUsel} = 00010, rd = 3, reg_write = 1.
REQ-022 sub x3,x1,x2 (0x402081B3) with exmem_wen = 1, exmem_rd = 1, exmem_result = 0x10, memwb_wen = 1, memwb_rd = 1, memwb_result = 0x20 -> SrcA = 0x10 and encoding 01010.
REQ-023 srai x5,x6,3 (0x40335293) -> SrcB = imm = 3, encoding 00101; instruction with rs1 = 0 while exmem_rd = 0, exmem_wen = 1 -> SrcA = rs1_data.
REQ-024 Held instruction with out_ready = 0 for 3 cycles while a new in_valid is presented -> in_ready = 0 and outputs unchanged; out_ready = 1 -> new instruction loads on the same edge.
REQ-025 flush and in_valid asserted together on the same edge -> out_valid = 0 next cycle; rst asserted mid-stall -> all outputs at their reset values next edge.
REQ-026 Opcode 0x7F -> illegal = 1, reg_write = 0, out_valid = 1.
